mem_bus_arbiter: RTL and testbench

- Shares the single synchronous data memory between two masters:
  - port 0: the core load/store path, using the core's req/stall protocol;
  - port 1: a secondary master such as a DMA or debug loader, using req/gnt/rvalid.
- Sits inside processor_system between core, data memory and the port-1 master.
- Sequences one access per cycle with round-robin arbitration.
- Generates the core stall signal.

---
 rtl/mem_bus_arbiter_if.sv | 48 ++++
 rtl/mem_bus_arbiter.sv | 70 +++++++
 tb/tb_mem_bus_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for mem_bus_arbiter: core port, port-1 master and memory side.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              core_req_i;
  logic              core_we_i;
  logic [2:0]        core_size_i;
  logic [ADDR_W-1:0] core_addr_i;
  logic [DATA_W-1:0] core_wd_i;
  logic [DATA_W-1:0] core_rd_o;
  logic              core_stall_o;

  logic              m1_req_i;
  logic              m1_we_i;
  logic [2:0]        m1_size_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_wd_i;
  logic              m1_gnt_o;
  logic              m1_rvalid_o;
  logic [DATA_W-1:0] m1_rd_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [2:0]        mem_size_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wd_o;
  logic [DATA_W-1:0] mem_rd_i;

  modport slave (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    output core_rd_o, core_stall_o,
    input  m1_req_i, m1_we_i, m1_size_i, m1_addr_i, m1_wd_i,
    output m1_gnt_o, m1_rvalid_o, m1_rd_o,
    output mem_req_o, mem_we_o, mem_size_o, mem_addr_o, mem_wd_o,
    input  mem_rd_i
  );

  modport master (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    input  core_rd_o, core_stall_o,
    output m1_req_i, m1_we_i, m1_size_i, m1_addr_i, m1_wd_i,
    input  m1_gnt_o, m1_rvalid_o, m1_rd_o,
    input  mem_req_o, mem_we_o, mem_size_o, mem_addr_o, mem_wd_o,
    output mem_rd_i
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the single-cycle data memory: one access per cycle,
// round-robin by default, fixed core priority when MEM_ARB_FIXED_PRIO_EN is defined.
module mem_bus_arbiter (
  input  logic             clk_i,
  input  logic             rst_i,
  mem_bus_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RESP0 = 2'd1;
  localparam logic [1:0] RESP1 = 2'd2;

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;
  logic       elig0, elig1, win0, win1;

  always_comb begin
    // The core still holds req during its retire cycle, so it is not eligible in RESP0.
    elig0 = bus.core_req_i && (state_q != RESP0);
    elig1 = bus.m1_req_i;
    win0  = 1'b0;
    win1  = 1'b0;
    if (elig0 && elig1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      win0 = 1'b1;
`else
      win0 = last_q;
      win1 = ~last_q;
`endif
    end else begin
      win0 = elig0;
      win1 = elig1;
    end
    win0 = win0 && rst_i;
    win1 = win1 && rst_i;

    state_d = IDLE;
    last_d  = last_q;
    if (win0) begin
      state_d = RESP0;
      last_d  = 1'b0;
    end else if (win1) begin
      state_d = RESP1;
      last_d  = 1'b1;
    end
  end

  // Control state; reset leaves last_q=1 so the core wins the first tie.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign bus.mem_req_o   = win0 || win1;
  assign bus.mem_we_o    = win1 ? bus.m1_we_i   : bus.core_we_i;
  assign bus.mem_size_o  = win1 ? bus.m1_size_i : bus.core_size_i;
  assign bus.mem_addr_o  = win1 ? bus.m1_addr_i : bus.core_addr_i;
  assign bus.mem_wd_o    = win1 ? bus.m1_wd_i   : bus.core_wd_i;

  assign bus.m1_gnt_o    = win1;
  assign bus.m1_rvalid_o = rst_i && (state_q == RESP1);
  assign bus.core_stall_o = bus.core_req_i && (state_q != RESP0);

  assign bus.core_rd_o   = bus.mem_rd_i;
  assign bus.m1_rd_o     = bus.mem_rd_i;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter against a transaction-level model with
// its own copy of memory contents and latency-bound tracking.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_bus_arbiter dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_arr [64];
  logic [31:0] ref_mem [64];

  bit          core_resp, m1_resp, last_srv;
  bit          core_rd_chk, m1_rd_chk;
  logic [31:0] exp_core_rd, exp_m1_rd;
  bit          core_done, m1_granted;
  int          stall_run, m1_wait;
  bit          rec_req, rec_we;
  logic [5:0]  rec_idx;
  logic [31:0] rec_wd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic run_cycle();
    bit want0, want1, pick1, issue;
    logic [5:0] idx;
    @(negedge clk);
    core_done  = 1'b0;
    m1_granted = 1'b0;
    rec_req    = 1'b0;
    if (!rst) begin
      chk("rst_mem_req", 64'(bus.mem_req_o), 64'(0));
      chk("rst_m1_gnt", 64'(bus.m1_gnt_o), 64'(0));
      chk("rst_m1_rvalid", 64'(bus.m1_rvalid_o), 64'(0));
      core_resp = 1'b0; m1_resp = 1'b0; last_srv = 1'b1;
      core_rd_chk = 1'b0; m1_rd_chk = 1'b0;
      stall_run = 0; m1_wait = 0;
    end else begin
      want0 = bus.core_req_i && !core_resp;
      want1 = bus.m1_req_i;
`ifdef MEM_ARB_FIXED_PRIO_EN
      pick1 = want1 && !want0;
`else
      pick1 = (want0 && want1) ? !last_srv : want1;
`endif
      issue = want0 || want1;
      chk("mem_req", 64'(bus.mem_req_o), 64'(issue));
      chk("m1_gnt", 64'(bus.m1_gnt_o), 64'(issue && pick1));
      chk("m1_rvalid", 64'(bus.m1_rvalid_o), 64'(m1_resp));
      chk("core_stall", 64'(bus.core_stall_o), 64'(bus.core_req_i && !core_resp));
      if (issue) begin
        chk("mem_addr", 64'(bus.mem_addr_o), 64'(pick1 ? bus.m1_addr_i : bus.core_addr_i));
        chk("mem_we", 64'(bus.mem_we_o), 64'(pick1 ? bus.m1_we_i : bus.core_we_i));
        chk("mem_size", 64'(bus.mem_size_o), 64'(pick1 ? bus.m1_size_i : bus.core_size_i));
        if (pick1 ? bus.m1_we_i : bus.core_we_i)
          chk("mem_wd", 64'(bus.mem_wd_o), 64'(pick1 ? bus.m1_wd_i : bus.core_wd_i));
      end
      if (core_resp && core_rd_chk) chk("core_rd", 64'(bus.core_rd_o), 64'(exp_core_rd));
      if (m1_resp && m1_rd_chk) chk("m1_rd", 64'(bus.m1_rd_o), 64'(exp_m1_rd));

      stall_run = bus.core_stall_o ? stall_run + 1 : 0;
`ifdef MEM_ARB_FIXED_PRIO_EN
      if (bus.core_stall_o) chk("core_stall_len_le1", 64'(stall_run <= 1), 64'(1));
`else
      if (bus.core_stall_o) chk("core_stall_len_le2", 64'(stall_run <= 2), 64'(1));
      m1_wait = (bus.m1_req_i && !bus.m1_gnt_o) ? m1_wait + 1 : 0;
      if (bus.m1_req_i) chk("m1_wait_le2", 64'(m1_wait <= 2), 64'(1));
`endif

      // Advance the transaction model and its private copy of memory.
      core_done  = core_resp && bus.core_req_i;
      m1_granted = issue && pick1;
      core_resp  = issue && !pick1;
      m1_resp    = issue && pick1;
      if (issue) last_srv = pick1;
      if (issue) begin
        idx = pick1 ? bus.m1_addr_i[7:2] : bus.core_addr_i[7:2];
        if (pick1) begin
          m1_rd_chk = !bus.m1_we_i; exp_m1_rd = ref_mem[idx];
          if (bus.m1_we_i) ref_mem[idx] = bus.m1_wd_i;
        end else begin
          core_rd_chk = !bus.core_we_i; exp_core_rd = ref_mem[idx];
          if (bus.core_we_i) ref_mem[idx] = bus.core_wd_i;
        end
      end
      rec_req = bus.mem_req_o; rec_we = bus.mem_we_o;
      rec_idx = bus.mem_addr_o[7:2]; rec_wd = bus.mem_wd_o;
    end
    @(posedge clk);
    #1;
    // Environment memory: registered read, write on request.
    if (rec_req) begin
      bus.mem_rd_i = mem_arr[rec_idx];
      if (rec_we) mem_arr[rec_idx] = rec_wd;
    end else begin
      bus.mem_rd_i = $urandom;
    end
  endtask

  task automatic new_core();
    bus.core_req_i  = ($urandom_range(0, 3) != 0);
    bus.core_we_i   = 1'($urandom_range(0, 1));
    bus.core_size_i = 3'($urandom_range(0, 2));
    bus.core_addr_i = 32'($urandom_range(0, 15)) << 2;
    bus.core_wd_i   = $urandom;
  endtask

  task automatic new_m1();
    bus.m1_req_i  = ($urandom_range(0, 3) != 0);
    bus.m1_we_i   = 1'($urandom_range(0, 1));
    bus.m1_size_i = 3'($urandom_range(0, 2));
    bus.m1_addr_i = 32'($urandom_range(0, 15)) << 2;
    bus.m1_wd_i   = $urandom;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    for (int i = 0; i < cycles; i++) run_cycle();
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    bus.mem_rd_i = '0;
    bus.core_req_i = 1'b1; bus.core_we_i = 1'b0; bus.core_size_i = 3'd2;
    bus.core_addr_i = 32'h10; bus.core_wd_i = '0;
    bus.m1_req_i = 1'b0; bus.m1_we_i = 1'b0; bus.m1_size_i = 3'd2;
    bus.m1_addr_i = '0; bus.m1_wd_i = '0;

    // Reset with core requesting, then core-only load of 0x10 and its retire.
    do_reset(2);
    run_cycle();
    run_cycle();
    bus.core_req_i = 1'b0;
    run_cycle();

    // Port-1 write of 0x1234 to 0x20, then its response cycle.
    bus.m1_req_i = 1'b1; bus.m1_we_i = 1'b1; bus.m1_addr_i = 32'h20; bus.m1_wd_i = 32'h1234;
    run_cycle();
    bus.m1_req_i = 1'b0;
    run_cycle();

    // Port 1 in RESP1 with a fresh request while the core issues.
    bus.m1_req_i = 1'b1; bus.m1_we_i = 1'b0; bus.m1_addr_i = 32'h20;
    run_cycle();
    bus.core_req_i = 1'b1; bus.core_we_i = 1'b0; bus.core_addr_i = 32'h20;
    run_cycle();
    run_cycle();
    bus.m1_req_i = 1'b0;
    run_cycle();
    bus.core_req_i = 1'b0;
    run_cycle();

    // Simultaneous requests right after reset, then sustained random traffic.
    do_reset(1);
    bus.core_req_i = 1'b1; bus.m1_req_i = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      run_cycle();
      if (!rst) begin
        rst = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
      end else begin
        if (!bus.core_req_i || core_done) new_core();
        if (!bus.m1_req_i || m1_granted) new_m1();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
